// File: rtl/fetch_pkg.sv
// Shared constants and the PC-tagged instruction record used by the fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          INSTR_BYTES      = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage: redirect input, imem request/response, decode handoff.
// master = fetch unit, slave = surrounding pipeline / instruction memory.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [DATA_WIDTH-1:0] if_pc;
    logic                  if_ready;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/sync_fifo.sv
// Small register-based FIFO with flush; head is read straight from storage (no bypass).
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and buffers
// PC-tagged instructions for decode. Optional perf counters under `FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_flushes
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop;
    logic [CW-1:0]         w_fifo_count;
    logic [CW-1:0]         w_pcq_count;
    logic [DATA_WIDTH-1:0] w_pcq_head;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head_entry;
    logic                  w_credit;
    logic                  w_req;
    logic                  w_grant;
    logic                  w_rsp;
    logic                  w_keep;
    logic                  w_valid;
    logic                  w_pop;

    // Buffered plus in-flight never exceeds the FIFO depth, so a kept response always fits.
    assign w_credit = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < (CW+1)'(FIFO_DEPTH);
    assign w_req    = rst_n && w_credit && !bus.redirect;
    assign w_grant  = w_req && bus.imem_gnt;
    assign w_rsp    = bus.imem_rvalid && (r_outstanding != '0);
    assign w_keep   = w_rsp && (r_drop == '0) && !bus.redirect && (w_pcq_count != '0);
    assign w_valid  = (w_fifo_count != '0);
    assign w_pop    = w_valid && bus.if_ready;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.if_valid  = w_valid;
    assign bus.if_instr  = w_head_entry.instr;
    assign bus.if_pc     = w_head_entry.pc;
    assign w_push_entry  = {w_pcq_head, bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
            if (bus.redirect) begin
                r_fetch_pc <= {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
                // Everything still in flight after this cycle belongs to the wrong path.
                r_drop     <= r_outstanding - CW'(w_rsp);
            end else begin
                if (w_grant) r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(INSTR_BYTES);
                if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    // PC tags of right-path requests only; wrong-path tags are flushed on redirect.
    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (bus.redirect),
        .i_push      (w_grant),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_keep),
        .o_head      (w_pcq_head),
        .o_count     (w_pcq_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (bus.redirect),
        .i_push      (w_keep),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head_entry),
        .o_count     (w_fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_pop)        r_perf_fetched <= r_perf_fetched + 32'd1;
            if (bus.redirect) r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
`else
    assign perf_fetched = '0;
    assign perf_flushes = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural imem, scoreboard of granted fetches,
// table-driven redirect vectors and hand-written reset/backpressure/perf sequences.
module tb_fetch_unit;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;

    fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

    fetch_unit #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .perf_fetched (perf_fetched),
        .perf_flushes (perf_flushes)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mem_rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] target; int lat; bit dbl; logic [31:0] exp_pc; } redir_vec_t;

    mem_rsp_t    mem_q[$];
    exp_t        sb_q[$];
    redir_vec_t  vecs[5];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          grants, pops, redirs;
    bit          rst_drive, rst_held;
    bit          gnt_en, gnt_rand, ready_en, ready_rand;
    bit          redir_now, junk_rsp;
    bit          prev_redir, prev_req_wait, pop_seen;
    bit          last_req, last_valid;
    logic [31:0] redir_target, exp_fetch_pc, prev_addr, pop_pc;
    logic [31:0] last_perf_fetched, last_perf_flushes;

    function automatic logic [31:0] mk_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_cycle();
        @(negedge clk);
        rst_n           = rst_drive;
        bus.redirect    = redir_now;
        bus.redirect_pc = redir_target;
        bus.imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_en;
        bus.if_ready    = ready_rand ? ($urandom_range(0, 3) != 0) : ready_en;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        if (junk_rsp) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'h0BAD_0BAD;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mk_data(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        #1;
        last_req          = bus.imem_req;
        last_valid        = bus.if_valid;
        last_perf_fetched = perf_fetched;
        last_perf_flushes = perf_flushes;
        if (!rst_n) begin
            if (rst_held) begin
                check("rst_req", 32'(bus.imem_req), 32'd0);
                check("rst_valid", 32'(bus.if_valid), 32'd0);
                check("rst_perf_fetched", perf_fetched, 32'd0);
                check("rst_perf_flushes", perf_flushes, 32'd0);
            end
            rst_held = 1'b1;
        end else begin
            if (redir_now)  check("redir_noreq", 32'(bus.imem_req), 32'd0);
            if (prev_redir) check("flush_valid", 32'(bus.if_valid), 32'd0);
            if (prev_req_wait && !redir_now) begin
                check("hold_req", 32'(bus.imem_req), 32'd1);
                check("hold_addr", bus.imem_addr, prev_addr);
            end
            if (bus.if_valid && bus.if_ready) begin
                pops++;
                pop_seen = 1'b1;
                pop_pc   = bus.if_pc;
                $display("cycle %0d: deliver pc=%08h instr=%08h", cyc, bus.if_pc, bus.if_instr);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty: got pc %08h, expected no delivery (cycle %0d)", bus.if_pc, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("if_pc", bus.if_pc, e.pc);
                    check("if_instr", bus.if_instr, e.instr);
                end
            end
            if (bus.imem_req && bus.imem_gnt) begin
                grants++;
                check("issue_addr", bus.imem_addr, exp_fetch_pc);
                mem_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
                sb_q.push_back('{pc: exp_fetch_pc, instr: mk_data(exp_fetch_pc)});
                exp_fetch_pc += 32'd4;
            end
            if (redir_now) begin
                redirs++;
                sb_q.delete();
                exp_fetch_pc = {redir_target[31:2], 2'b00};
            end
            prev_redir    = redir_now;
            prev_req_wait = bus.imem_req && !bus.imem_gnt;
            prev_addr     = bus.imem_addr;
        end
        cyc++;
        @(posedge clk);
    endtask

    // Two reset cycles, then one cycle with no grant and a stray response that must be ignored.
    task automatic do_reset();
        rst_drive  = 1'b0;
        rst_held   = 1'b0;
        redir_now  = 1'b0;
        junk_rsp   = 1'b0;
        gnt_rand   = 1'b0;
        ready_rand = 1'b0;
        repeat (2) do_cycle();
        mem_q.delete();
        sb_q.delete();
        exp_fetch_pc  = RST_PC;
        prev_redir    = 1'b0;
        prev_req_wait = 1'b0;
        grants = 0;
        pops   = 0;
        redirs = 0;
        rst_drive = 1'b1;
        gnt_en    = 1'b0;
        junk_rsp  = 1'b1;
        do_cycle();
        junk_rsp  = 1'b0;
        gnt_en    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.if_ready    = 1'b0;
        redir_target    = '0;
        gnt_en = 1'b1; ready_en = 1'b1;

        vecs[0] = '{32'h8000_0010, 2, 1'b0, 32'h8000_0010};
        vecs[1] = '{32'h8000_0013, 1, 1'b0, 32'h8000_0010};
        vecs[2] = '{32'h0000_1002, 3, 1'b1, 32'h0000_1000};
        vecs[3] = '{32'hFFFF_FFF8, 1, 1'b0, 32'hFFFF_FFF8};
        vecs[4] = '{32'h7FFF_FFFD, 2, 1'b1, 32'h7FFF_FFFC};

        // Full-rate stream: first fetch at RESET_PC, one delivery per cycle from the third cycle.
        do_reset();
        lat = 1; ready_en = 1'b1;
        repeat (20) do_cycle();
        check("stream_pops", pops, 32'd18);

        // Backpressure: exactly DEPTH grants, then the request drops until decode drains.
        do_reset();
        lat = 1; ready_en = 1'b0;
        repeat (12) do_cycle();
        check("bp_grants", grants, DEPTH);
        check("bp_req_low", 32'(last_req), 32'd0);
        check("bp_valid", 32'(last_valid), 32'd1);
        ready_en = 1'b1;
        repeat (15) do_cycle();
        check("bp_resume_pops", pops, 32'd15);

        // Redirect vectors, with stale responses in flight (and a back-to-back redirect when dbl).
        do_reset();
        ready_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lat = vecs[i].lat;
            repeat (6) do_cycle();
            if (vecs[i].dbl) begin
                redir_now = 1'b1; redir_target = 32'h1234_5678;
                do_cycle();
            end
            redir_now = 1'b1; redir_target = vecs[i].target;
            do_cycle();
            redir_now = 1'b0;
            pop_seen  = 1'b0;
            for (int k = 0; k < 20 && !pop_seen; k++) do_cycle();
            if (!pop_seen) begin
                n_cmp++;
                n_err++;
                $display("FAIL redir_timeout: got no delivery, expected pc %08h", vecs[i].exp_pc);
            end else begin
                check("redir_first_pc", pop_pc, vecs[i].exp_pc);
            end
            repeat (4) do_cycle();
        end

        // Random grants, readiness, latency and redirects; then reset in the middle of traffic.
        gnt_rand = 1'b1; ready_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            lat          = $urandom_range(1, 3);
            redir_now    = ($urandom_range(0, 24) == 0);
            redir_target = $urandom();
            do_cycle();
        end
        redir_now = 1'b0;

        // Performance counters: 10 pops and 2 redirects.
        do_reset();
        lat = 1; ready_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (pops == 10 && redirs == 2) break;
            ready_en  = (pops < 10);
            redir_now = (pops >= 3 && redirs == 0) || (pops >= 6 && redirs == 1);
            do_cycle();
        end
        redir_now = 1'b0; ready_en = 1'b0;
        do_cycle();
        n_cmp++;
        if (!(pops == 10 && redirs == 2)) begin
            n_err++;
            $display("FAIL perf_setup: got %0d pops / %0d redirects, expected 10 / 2", pops, redirs);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", last_perf_fetched, pops);
        check("perf_flushes", last_perf_flushes, redirs);
`else
        check("perf_fetched", last_perf_fetched, 32'd0);
        check("perf_flushes", last_perf_flushes, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
